// File: rtl/para_seq.sv
// para_seq: acquisition sequencer that gates samples into the hit detector, captures hits,
// enforces a sample-counted holdoff and applies staged thresholds only at arm boundaries.
module para_seq #(
  parameter logic [15:0] TH_RST  = 16'h8000,
  parameter logic [31:0] HDT_RST = 32'd100,
  parameter logic [31:0] LDT_RST = 32'd100
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cfg_mode,
  input  logic [31:0] cfg_hold,
  input  logic [31:0] cfg_tmo,
  input  logic [15:0] new_th,
  input  logic [31:0] new_hdt,
  input  logic [31:0] new_ldt,
  input  logic        new_upd,
  input  logic        sm_vld,
  input  logic        ph_vld,
  input  logic [15:0] ph_ring,
  output logic        sm_vld_o,
  output logic [15:0] cfg_th,
  output logic [31:0] cfg_hdt,
  output logic [31:0] cfg_ldt,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_tmo,
  output logic [15:0] hit_cnt,
  output logic [15:0] last_ring
);
  typedef enum logic [1:0] {IDLE, ARM, WAIT, HOLD} state_t;
  state_t      r_state, w_next;
  logic        r_pend;
  logic [15:0] r_sh_th, r_hit_cnt, r_last_ring;
  logic [31:0] r_sh_hdt, r_sh_ldt, r_tmo_cnt, r_hold_cnt;
  logic        w_stop, w_hit, w_tmo, w_hexit, w_apply;
  assign sm_vld_o  = sm_vld && r_state == WAIT;
  assign seq_busy  = r_state != IDLE;
  assign hit_cnt   = r_hit_cnt;
  assign last_ring = r_last_ring;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next  = r_state;
    w_stop  = cmd_stop && r_state != IDLE;
    w_hit   = !w_stop && r_state == WAIT && ph_vld;
    w_tmo   = !w_stop && !w_hit && r_state == WAIT && cfg_tmo != 32'd0 && r_tmo_cnt == cfg_tmo - 32'd1;
    w_hexit = !w_stop && r_state == HOLD && r_hold_cnt == cfg_hold;
    w_apply = r_pend && (r_state == IDLE || r_state == ARM);
    case (r_state)
      IDLE:    w_next = cmd_start ? ARM : IDLE;
      ARM:     w_next = WAIT;
      WAIT:    w_next = w_hit ? HOLD : w_tmo ? IDLE : WAIT;
      HOLD:    w_next = w_hexit ? (cfg_mode ? ARM : IDLE) : HOLD;
      default: w_next = IDLE;
    endcase
    if (w_stop) w_next = IDLE;
  end
  // Shadow is applied before being overwritten, so an update racing ARM stays pending.
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      cfg_th      <= TH_RST;
      cfg_hdt     <= HDT_RST;
      cfg_ldt     <= LDT_RST;
      r_sh_th     <= TH_RST;
      r_sh_hdt    <= HDT_RST;
      r_sh_ldt    <= LDT_RST;
      r_pend      <= 1'b0;
      r_hit_cnt   <= 16'd0;
      r_last_ring <= 16'd0;
      r_tmo_cnt   <= 32'd0;
      r_hold_cnt  <= 32'd0;
      seq_done    <= 1'b0;
      seq_tmo     <= 1'b0;
    end else begin
      seq_done <= w_hexit && !cfg_mode;
      seq_tmo  <= w_tmo;
      if (w_apply) begin
        cfg_th  <= r_sh_th;
        cfg_hdt <= r_sh_hdt;
        cfg_ldt <= r_sh_ldt;
      end
      if (new_upd) begin
        r_sh_th  <= new_th;
        r_sh_hdt <= new_hdt;
        r_sh_ldt <= new_ldt;
      end
      r_pend <= new_upd || (r_pend && !w_apply);
      if (r_state == IDLE && cmd_start) begin
        r_hit_cnt   <= 16'd0;
        r_last_ring <= 16'd0;
      end
      if (w_hit) begin
        r_last_ring <= ph_ring;
        r_hit_cnt   <= r_hit_cnt + {15'd0, r_hit_cnt != 16'hFFFF};
      end
      r_tmo_cnt  <= r_state == ARM ? 32'd0 : r_state == WAIT ? r_tmo_cnt + 32'd1 : r_tmo_cnt;
      r_hold_cnt <= r_state == ARM ? 32'd0 : (r_state == HOLD && sm_vld) ? r_hold_cnt + 32'd1 : r_hold_cnt;
    end
endmodule

// File: tb/tb_para_seq.sv
// tb_para_seq: randomized and directed checks of para_seq against a phase-level reference model.
module tb_para_seq;
  logic        clk_sys = 0, rst_n = 0, cmd_start = 0, cmd_stop = 0, cfg_mode = 0;
  logic [31:0] cfg_hold = 0, cfg_tmo = 0, new_hdt = 0, new_ldt = 0;
  logic [15:0] new_th = 0, ph_ring = 0;
  logic        new_upd = 0, sm_vld = 0, ph_vld = 0;
  logic        sm_vld_o, seq_busy, seq_done, seq_tmo;
  logic [15:0] cfg_th, hit_cnt, last_ring;
  logic [31:0] cfg_hdt, cfg_ldt;
  para_seq dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cfg_mode(cfg_mode), .cfg_hold(cfg_hold), .cfg_tmo(cfg_tmo), .new_th(new_th),
    .new_hdt(new_hdt), .new_ldt(new_ldt), .new_upd(new_upd), .sm_vld(sm_vld),
    .ph_vld(ph_vld), .ph_ring(ph_ring), .sm_vld_o(sm_vld_o), .cfg_th(cfg_th),
    .cfg_hdt(cfg_hdt), .cfg_ldt(cfg_ldt), .seq_busy(seq_busy), .seq_done(seq_done),
    .seq_tmo(seq_tmo), .hit_cnt(hit_cnt), .last_ring(last_ring)
  );
  always #5 clk_sys = ~clk_sys;
  int n_chk = 0, n_bad = 0;
  typedef enum {P_IDLE, P_ARM, P_WAIT, P_HOLD} phase_t;
  phase_t      ph;
  longint      waited, held;
  logic [15:0] m_th, s_th, m_hits, m_ring;
  logic [31:0] m_hdt, m_ldt, s_hdt, s_ldt;
  bit          m_pend, m_done, m_tmo;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    ph = P_IDLE; waited = 0; held = 0;
    m_th = 16'h8000; s_th = 16'h8000; m_hdt = 100; s_hdt = 100; m_ldt = 100; s_ldt = 100;
    m_hits = 0; m_ring = 0; m_pend = 0; m_done = 0; m_tmo = 0;
  endtask
  task automatic model_step();
    m_done = 0; m_tmo = 0;
    if (m_pend && (ph == P_IDLE || ph == P_ARM)) begin
      m_th = s_th; m_hdt = s_hdt; m_ldt = s_ldt; m_pend = 0;
    end
    if (new_upd) begin
      s_th = new_th; s_hdt = new_hdt; s_ldt = new_ldt; m_pend = 1;
    end
    if (ph != P_IDLE && cmd_stop) ph = P_IDLE;
    else case (ph)
      P_IDLE: if (cmd_start) begin ph = P_ARM; m_hits = 0; m_ring = 0; end
      P_ARM: begin ph = P_WAIT; waited = 0; held = 0; end
      P_WAIT:
        if (ph_vld) begin
          m_ring = ph_ring;
          if (m_hits != 16'hFFFF) m_hits++;
          ph = P_HOLD;
        end else if (cfg_tmo != 0 && waited + 1 == cfg_tmo) begin
          ph = P_IDLE; m_tmo = 1;
        end else waited++;
      P_HOLD:
        if (held == cfg_hold) begin
          ph = cfg_mode ? P_ARM : P_IDLE;
          m_done = !cfg_mode;
        end else if (sm_vld) held++;
    endcase
  endtask
  task automatic check_all();
    chk("sm_vld_o", sm_vld_o, sm_vld && ph == P_WAIT);
    chk("busy", seq_busy, ph != P_IDLE);
    chk("done", seq_done, m_done);
    chk("tmo", seq_tmo, m_tmo);
    chk("hit_cnt", hit_cnt, m_hits);
    chk("last_ring", last_ring, m_ring);
    chk("cfg_th", cfg_th, m_th);
    chk("cfg_hdt", cfg_hdt, m_hdt);
    chk("cfg_ldt", cfg_ldt, m_ldt);
  endtask
  task automatic tick();
    @(negedge clk_sys);
    check_all();
    @(posedge clk_sys);
    if (rst_n) model_step(); else model_reset();
    #1;
    cmd_start = 0; cmd_stop = 0; new_upd = 0; ph_vld = 0;
  endtask
  task automatic go_wait();
    cmd_start = 1;
    tick();
    tick();
  endtask
  task automatic hit(input logic [15:0] ring);
    ph_vld = 1; ph_ring = ring;
    tick();
  endtask
  initial begin
    model_reset();
    sm_vld = 1;
    tick(); tick();
    rst_n = 1;
    chk("t1_th", cfg_th, 16'h8000);
    chk("t1_hdt", cfg_hdt, 32'd100);
    chk("t1_ldt", cfg_ldt, 32'd100);
    chk("t1_busy", seq_busy, 0);
    chk("t1_gate", sm_vld_o, 0);
    cfg_mode = 0; cfg_hold = 3; cfg_tmo = 0;
    go_wait();
    repeat (4) tick();
    hit(16'h1234);
    repeat (4) tick();
    chk("t2_done", seq_done, 1);
    chk("t2_ring", last_ring, 16'h1234);
    chk("t2_hits", hit_cnt, 1);
    chk("t2_busy", seq_busy, 0);
    tick();
    chk("t2_done_once", seq_done, 0);
    cfg_mode = 1; cfg_hold = 0;
    go_wait();
    for (int i = 0; i < 3; i++) begin
      tick();
      hit(16'h0100 + 16'(i));
      chk("t3_gate_hold", sm_vld_o, 0);
      tick();
      chk("t3_rearm", seq_busy, 1);
      tick();
    end
    chk("t3_hits", hit_cnt, 3);
    cmd_stop = 1;
    tick();
    chk("t3_stop_busy", seq_busy, 0);
    chk("t3_stop_hits", hit_cnt, 3);
    chk("t3_stop_done", seq_done, 0);
    tick();
    cfg_mode = 0; cfg_tmo = 10;
    go_wait();
    repeat (10) tick();
    chk("t4_tmo", seq_tmo, 1);
    chk("t4_done", seq_done, 0);
    tick();
    go_wait();
    repeat (9) tick();
    hit(16'hBEEF);
    chk("t4_late_hit", hit_cnt, 1);
    chk("t4_no_tmo", seq_tmo, 0);
    repeat (5) tick();
    cfg_mode = 1; cfg_hold = 0; cfg_tmo = 0;
    go_wait();
    tick();
    new_upd = 1; new_th = 16'h0040; new_hdt = 32'd7; new_ldt = 32'd9;
    tick();
    repeat (3) tick();
    chk("t5_hold_th", cfg_th, 16'h8000);
    hit(16'h0001);
    tick();
    chk("t5_arm_th", cfg_th, 16'h8000);
    tick();
    chk("t5_new_th", cfg_th, 16'h0040);
    new_upd = 1; new_th = 16'h0011;
    tick();
    new_upd = 1; new_th = 16'h0022;
    tick();
    hit(16'h0002);
    tick(); tick();
    chk("t5_last_wins", cfg_th, 16'h0022);
    cmd_stop = 1;
    tick();
    cfg_hold = 1; sm_vld = 1;
    go_wait();
    force dut.r_hit_cnt = 16'hFFFE;
    #1;
    release dut.r_hit_cnt;
    m_hits = 16'hFFFE;
    hit(16'h0A0A);
    tick(); tick(); tick();
    hit(16'h0B0B);
    chk("t6_sat", hit_cnt, 16'hFFFF);
    sm_vld = 0;
    tick(); tick();
    chk("t6_in_hold", seq_busy, 1);
    #2 rst_n = 0;
    #1 model_reset();
    chk("t6_rst_busy", seq_busy, 0);
    chk("t6_rst_hits", hit_cnt, 0);
    chk("t6_rst_ring", last_ring, 0);
    chk("t6_rst_th", cfg_th, 16'h8000);
    check_all();
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      if (ph == P_IDLE && $urandom_range(0, 3) == 0) begin
        cfg_mode = 1'($urandom_range(0, 1));
        cfg_hold = $urandom_range(0, 4);
        cfg_tmo  = $urandom_range(0, 12);
      end
      cmd_start = $urandom_range(0, 7) == 0;
      cmd_stop  = $urandom_range(0, 40) == 0;
      ph_vld    = $urandom_range(0, 5) == 0;
      ph_ring   = 16'($urandom);
      sm_vld    = 1'($urandom_range(0, 1));
      new_upd   = $urandom_range(0, 15) == 0;
      new_th    = 16'($urandom);
      new_hdt   = $urandom;
      new_ldt   = $urandom;
      tick();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/para_seq.md
Name: para_seq

Overview:
Acquisition sequencer in front of the parameter hit-detection path. It arms a measurement window on command and gates the sample stream (sm_vld) into the hit detector only while waiting for a hit. It captures the ring value on each hit, enforces a post-hit holdoff counted in samples, and either re-arms or finishes. It also owns the threshold/dead-time configuration and applies register-bus updates only at arm boundaries, so a running window never sees a mid-window change.

Parameters:
TH_RST, 16'h8000, reset value of cfg_th
HDT_RST, 32'd100, reset value of cfg_hdt
LDT_RST, 32'd100, reset value of cfg_ldt

Ports:
clk_sys  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_start  in  1  1-cycle start pulse
cmd_stop  in  1  1-cycle abort pulse
cfg_mode  in  1  0=single shot, 1=continuous re-arm
cfg_hold  in  32  holdoff length in sm_vld samples
cfg_tmo  in  32  WAIT timeout in clk_sys cycles; 0 disables timeout
new_th  in  16  staged threshold
new_hdt  in  32  staged high dead time
new_ldt  in  32  staged low dead time
new_upd  in  1  1-cycle pulse: capture new_* into the pending shadow
sm_vld  in  1  sample valid from the sample path
ph_vld  in  1  hit strobe from the hit detector
ph_ring  in  16  ring value accompanying ph_vld
sm_vld_o  out  1  gated sample valid to the hit detector
cfg_th  out  16  applied threshold
cfg_hdt  out  32  applied high dead time
cfg_ldt  out  32  applied low dead time
seq_busy  out  1  state != IDLE
seq_done  out  1  1-cycle pulse: window completed normally
seq_tmo  out  1  1-cycle pulse: WAIT timed out
hit_cnt  out  16  hits since last start, saturating
last_ring  out  16  ph_ring of the most recent accepted hit

Behaviour:
- Reset values: state=IDLE; cfg_th/hdt/ldt = TH_RST/HDT_RST/LDT_RST; pending flag=0; hit_cnt=0; last_ring=0; seq_done=0; seq_tmo=0; counters=0.
- Only ports are clk_sys/rst_n for clock/reset. Reset is asynchronous and active-low and may assert in any state: all state returns to reset values immediately.
- sm_vld_o = sm_vld & (state==WAIT). Combinational, zero latency.
- seq_busy is decoded from the state register.
- States:
  - IDLE:
    - cmd_start -> ARM; clears hit_cnt and last_ring.
    - A pending update is applied here on the cycle after new_upd.
  - ARM (exactly 1 cycle):
    - If pending=1, copy the shadow to cfg_* and clear pending.
    - Clear tmo_cnt and hold_cnt.
    - -> WAIT.
  - WAIT:
    - tmo_cnt increments each cycle.
    - ph_vld=1: last_ring<=ph_ring, hit_cnt+1 (saturates at 16'hFFFF), -> HOLD.
    - Else if cfg_tmo!=0 and tmo_cnt==cfg_tmo-1: -> IDLE with seq_tmo=1. WAIT therefore lasts exactly cfg_tmo cycles.
  - HOLD:
    - hold_cnt increments on sm_vld.
    - When hold_cnt==cfg_hold: cfg_mode=1 -> ARM; cfg_mode=0 -> IDLE with seq_done=1.
    - cfg_hold=0 gives exactly one HOLD cycle.
    - ph_vld in HOLD is ignored: no count, no capture.
- Latency: cmd_start at cycle t -> ARM at t+1, WAIT (gate open) at t+2. ph_vld at cycle h -> hit_cnt and last_ring visible at h+1, sm_vld_o low from h+1.
- seq_done and seq_tmo are registered and high for the first IDLE cycle only.
- Priority, highest first:
  1. cmd_stop in any non-IDLE state -> IDLE next cycle. No done/tmo pulse; hit_cnt and last_ring are retained.
  2. ph_vld.
  3. Timeout.
  4. Holdoff exit.
- cmd_start outside IDLE is ignored.
- cmd_start and cmd_stop together in IDLE: start wins (stop has no effect in IDLE).
- new_upd at any time overwrites the shadow and sets pending; the last update before the next ARM wins.
- new_upd in the same cycle as ARM: ARM applies the old shadow; the new value stays pending for the next ARM or IDLE.
- In IDLE, pending is applied one cycle after new_upd.
- cfg_* never change while the state is WAIT or HOLD.
- cfg_hold and cfg_tmo are sampled live, not shadowed; software changes them only while idle.

Test Plan:
1. Reset, then check outputs: cfg_th=16'h8000, cfg_hdt=100, cfg_ldt=100, seq_busy=0, sm_vld_o=0 with sm_vld=1.
2. Single shot, cfg_hold=3. Start, ph_vld with ph_ring=16'h1234 at the 5th WAIT cycle, then 3 sm_vld -> last_ring=16'h1234, hit_cnt=1, seq_done pulse once, IDLE; sm_vld_o low through HOLD.
3. Continuous, cfg_hold=0. Three hits -> states cycle ARM/WAIT/HOLD, hit_cnt=3, no seq_done; cmd_stop -> IDLE next cycle, hit_cnt stays 3, no pulses.
4. cfg_tmo=10, no hits -> WAIT lasts exactly 10 cycles, seq_tmo pulses, seq_done stays 0. Repeat with ph_vld on the 10th WAIT cycle -> hit accepted, no tmo.
5. Start with new_th=16'h0040 written mid-WAIT, continuous mode -> cfg_th unchanged until the next ARM, then 16'h0040. Two writes before that ARM -> the second value is applied.
6. Force hit_cnt to 16'hFFFE, two more hits -> saturates at 16'hFFFF. Assert rst_n low mid-HOLD -> immediate IDLE with all reset values.
